frame_phase_scheduler: RTL and testbench
========================================

Name: frame_phase_scheduler

Overview:
Per-frame sequencer driven by the frame-advance strobe (gameSCEN). On each accepted frame tick it starts the game's update stages in fixed order (e.g. input sample, move, collide, score/render-commit). Each stage gets a one-cycle start pulse and the scheduler waits for that stage's done before moving on. It also reports overruns (a tick arriving mid-frame) and stage timeouts, and supports pause.

Parameters:
NUM_PHASES, 4, number of sequenced update stages (2..8)
PH_W, 2, width of phase index; must satisfy 2^PH_W >= NUM_PHASES
TIMEOUT_CYCLES, 1024, maximum cycles allowed in one stage before abort
TO_W, 10, watchdog counter width; must satisfy 2^TO_W >= TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  reset, synchronous, active-low (asserted when 0)
frame_tick  in  1  one-cycle frame strobe (gameSCEN)
pause  in  1  debounced level; blocks new frames when high
phase_done  in  NUM_PHASES  per-stage completion; a stage asserts its bit for at least one cycle
phase_start  out  NUM_PHASES  one-hot, one-cycle start pulse to a stage
cur_phase  out  PH_W  index of the active or last-started stage
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse when the last stage completes
overrun  out  1  one-cycle pulse when a tick is dropped because busy is high
overrun_cnt  out  8  saturating count of overruns
timeout_err  out  1  sticky flag; cleared only by reset

Behaviour:
- Reset (rst==0 at posedge) forces state IDLE and sets cur_phase=0, phase_start=0, busy=0, frame_done=0, overrun=0, overrun_cnt=0, timeout_err=0, watchdog=0. Reset mid-frame abandons the frame; no frame_done is issued.
- State machine has three states: IDLE, START, WAIT_DONE.
- IDLE:
  - frame_tick=1 and pause=0 -> START with cur_phase=0.
  - frame_tick=1 and pause=1 -> stay in IDLE. The tick is silently dropped and does not count as an overrun.
- START:
  - phase_start[cur_phase]=1 for exactly this cycle. Decode is from state, so the pulse appears one cycle after the tick.
  - Watchdog cleared. -> WAIT_DONE.
- WAIT_DONE: the watchdog increments each cycle.
  - phase_done[cur_phase]=1 and cur_phase<NUM_PHASES-1 -> cur_phase+1, go to START.
  - phase_done[cur_phase]=1 and cur_phase==NUM_PHASES-1 -> frame_done pulse next cycle, go to IDLE.
  - Watchdog==TIMEOUT_CYCLES-1 with no done -> set timeout_err, go to IDLE. No frame_done is issued; cur_phase holds the failing stage.
  - Done and timeout in the same cycle: done wins.
  - phase_done bits of non-active stages are ignored at all times.
- busy=1 in START and WAIT_DONE.
- frame_tick while busy: the tick is dropped and never queued. overrun pulses next cycle and overrun_cnt increments, saturating at 255.
- pause rising mid-frame does not stop the frame; it only gates the next tick.
- Timing: each stage costs (done latency + 1) cycles. Minimum frame length with done returned the cycle after start is 2*NUM_PHASES cycles from the first phase_start to IDLE.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.

Optional Feature:
Macro: FRAME_PHASE_SCHED_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0]. It is reset to 0, increments on every frame_done, and wraps 65535->0. Aborted and dropped frames do not count.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package game_pkg holds:
  - state encodings (IDLE/START/WAIT_DONE);
  - default NUM_PHASES and TIMEOUT_CYCLES;
  - stage index names (PH_INPUT=0, PH_MOVE=1, PH_COLLIDE=2, PH_COMMIT=3).
- One sub-module, phase_watchdog: a clear/enable/terminal-count counter, parameterised by TO_W and TIMEOUT_CYCLES, producing an expire pulse.
- The overrun saturating counter stays inline.

Test Plan:
- Nominal frame: tick at cycle 10 with each done returned 3 cycles after its start -> phase_start pulses at cycles 11, 15, 19, 23 for stages 0..3; frame_done at 27; busy is low from 27.
- Overrun: tick at 10, stage 1 delays done by 50 cycles, second tick at 30 -> overrun pulse at 31, overrun_cnt=1, frame completes normally, no second frame starts.
- Timeout: TIMEOUT_CYCLES=16, stage 2 never completes -> timeout_err=1 after 16 WAIT_DONE cycles, cur_phase=2, no frame_done; next tick starts a new frame at stage 0.
- Pause: pause=1 with 3 ticks -> no phase_start, overrun_cnt stays 0. Pause asserted mid-frame -> that frame still completes.
- Reset and saturation: 300 overruns -> overrun_cnt=255. rst=0 during stage 1 -> all outputs are 0 the next cycle and no frame_done is issued.
- Edge cases: done on a non-active stage bit -> ignored. Done arriving on the same cycle the watchdog expires -> advance, timeout_err stays 0. With FRAME_PHASE_SCHED_FRAME_CNT_EN defined, 3 completed frames -> frame_cnt=3.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encodings, default sizing and stage names for the frame scheduler.
package game_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;
    localparam int DEF_NUM_PHASES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int PH_INPUT   = 0;
    localparam int PH_MOVE    = 1;
    localparam int PH_COLLIDE = 2;
    localparam int PH_COMMIT  = 3;
endpackage

// File: rtl/phase_watchdog.sv
// phase_watchdog: clearable stage timer; o_expire is high while enabled at the terminal count.
module phase_watchdog #(
    parameter int TO_W           = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    logic [TO_W-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clr)
            r_cnt <= '0;
        else if (i_en && !o_expire)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/frame_phase_scheduler.sv
// frame_phase_scheduler: per-frame sequencer that starts each update stage in order and waits for its done.
// Define FRAME_PHASE_SCHED_FRAME_CNT_EN to add the o_frame_cnt completed-frame counter.
module frame_phase_scheduler
    import game_pkg::*;
#(
    parameter int NUM_PHASES     = DEF_NUM_PHASES,
    parameter int PH_W           = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_W           = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_frame_tick,
    input  logic                  i_pause,
    input  logic [NUM_PHASES-1:0] i_phase_done,
    output logic [NUM_PHASES-1:0] o_phase_start,
    output logic [PH_W-1:0]       o_cur_phase,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_overrun,
    output logic [7:0]            o_overrun_cnt,
`ifdef FRAME_PHASE_SCHED_FRAME_CNT_EN
    output logic [15:0]           o_frame_cnt,
`endif
    output logic                  o_timeout_err
);
    state_t                r_state;
    logic [NUM_PHASES-1:0] r_phase_start;
    logic [PH_W-1:0]       r_cur_phase;
    logic                  r_frame_done;
    logic                  r_overrun;
    logic [7:0]            r_overrun_cnt;
    logic                  r_timeout_err;
    logic                  w_done;
    logic                  w_last;
    logic                  w_expire;
    logic [PH_W-1:0]       w_next;

    assign w_done = i_phase_done[r_cur_phase];
    assign w_last = r_cur_phase == PH_W'(NUM_PHASES - 1);
    assign w_next = r_cur_phase + 1'b1;

    assign o_phase_start = r_phase_start;
    assign o_cur_phase   = r_cur_phase;
    assign o_busy        = r_state != IDLE;
    assign o_frame_done  = r_frame_done;
    assign o_overrun     = r_overrun;
    assign o_overrun_cnt = r_overrun_cnt;
    assign o_timeout_err = r_timeout_err;

    phase_watchdog #(
        .TO_W          (TO_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (r_state == START),
        .i_en    (r_state == WAIT_DONE),
        .o_expire(w_expire)
    );

    // The start pulse is loaded on the transition into START so it is high exactly for that state.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= IDLE;
            r_phase_start <= '0;
            r_cur_phase   <= '0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_phase_start <= '0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            if (i_frame_tick && r_state != IDLE) begin
                r_overrun <= 1'b1;
                if (r_overrun_cnt != 8'hFF)
                    r_overrun_cnt <= r_overrun_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_frame_tick && !i_pause) begin
                        r_state       <= START;
                        r_cur_phase   <= PH_W'(PH_INPUT);
                        r_phase_start <= NUM_PHASES'(1);
                    end
                end
                START: r_state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (w_done && w_last) begin
                        r_state      <= IDLE;
                        r_frame_done <= 1'b1;
                    end else if (w_done) begin
                        r_state       <= START;
                        r_cur_phase   <= w_next;
                        r_phase_start <= NUM_PHASES'(1) << w_next;
                    end else if (w_expire) begin
                        r_state       <= IDLE;
                        r_timeout_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_PHASE_SCHED_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    assign o_frame_cnt = r_frame_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_frame_cnt <= '0;
        else if (r_state == WAIT_DONE && w_done && w_last)
            r_frame_cnt <= r_frame_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_frame_phase_scheduler.sv
// tb_frame_phase_scheduler: directed scenarios with an event scoreboard for start/done/overrun pulses.
// Cycle k is the interval following the k-th rising edge; inputs change 1 time unit after that edge.
module tb_frame_phase_scheduler;
    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_frame_tick = 1'b0;
    logic        i_pause = 1'b0;
    logic [3:0]  i_phase_done = '0;
    logic [3:0]  o_phase_start;
    logic [1:0]  o_cur_phase;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_overrun;
    logic [7:0]  o_overrun_cnt;
    logic        o_timeout_err;
`ifdef FRAME_PHASE_SCHED_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    typedef struct {
        int         c;
        logic [3:0] ps;
        logic       fd;
        logic       ov;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         dly[4] = '{0, 0, 0, 0};
    int         cd[4] = '{-1, -1, -1, -1};
    logic [3:0] extra_done = '0;

    frame_phase_scheduler #(
        .NUM_PHASES    (4),
        .PH_W          (2),
        .TIMEOUT_CYCLES(64),
        .TO_W          (6)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_frame_tick (i_frame_tick),
        .i_pause      (i_pause),
        .i_phase_done (i_phase_done),
        .o_phase_start(o_phase_start),
        .o_cur_phase  (o_cur_phase),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_overrun    (o_overrun),
        .o_overrun_cnt(o_overrun_cnt),
`ifdef FRAME_PHASE_SCHED_FRAME_CNT_EN
        .o_frame_cnt  (o_frame_cnt),
`endif
        .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage model: a stage with latency L raises its done bit L cycles after its start pulse.
    initial begin
        logic [3:0] done_v;
        forever begin
            @(posedge clk);
            #1;
            done_v = '0;
            for (int p = 0; p < 4; p++) begin
                if (cd[p] == 1) begin
                    done_v[p] = 1'b1;
                    cd[p] = -1;
                end else if (cd[p] > 1) begin
                    cd[p] = cd[p] - 1;
                end
                if (o_phase_start[p] && dly[p] > 0)
                    cd[p] = dly[p];
            end
            i_phase_done = done_v | extra_done;
        end
    end

    always @(negedge clk) begin
        if (o_phase_start != 4'b0 || o_frame_done || o_overrun) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event: unexpected at cycle %0d ps=%b fd=%b ov=%b", cyc, o_phase_start, o_frame_done, o_overrun);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.c != cyc || e.ps != o_phase_start || e.fd != o_frame_done || e.ov != o_overrun) begin
                    errors++;
                    $display("FAIL event: got cycle %0d ps=%b fd=%b ov=%b, expected cycle %0d ps=%b fd=%b ov=%b",
                             cyc, o_phase_start, o_frame_done, o_overrun, e.c, e.ps, e.fd, e.ov);
                end
            end
        end
    end

    function automatic void push(int c, logic [3:0] ps, logic fd, logic ov);
        exp_q.push_back('{c, ps, fd, ov});
    endfunction

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic goto(int k);
        while (cyc != k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_at(int t);
        goto(t);
        i_frame_tick = 1'b1;
        goto(t + 1);
        i_frame_tick = 1'b0;
    endtask

    initial begin
        goto(3);
        chk("reset busy", int'(o_busy), 0);
        chk("reset cur_phase", int'(o_cur_phase), 0);
        chk("reset ovr_cnt", int'(o_overrun_cnt), 0);
        chk("reset timeout", int'(o_timeout_err), 0);
        goto(5);
        i_rst = 1'b1;

        // nominal frame, each done 3 cycles after its start
        dly = '{3, 3, 3, 3};
        push(11, 4'b0001, 0, 0);
        push(15, 4'b0010, 0, 0);
        push(19, 4'b0100, 0, 0);
        push(23, 4'b1000, 0, 0);
        push(27, 4'b0000, 1, 0);
        tick_at(10);
        goto(26);
        chk("nominal busy@26", int'(o_busy), 1);
        goto(27);
        chk("nominal busy@27", int'(o_busy), 0);
        chk("nominal cur_phase", int'(o_cur_phase), 3);

        // overrun: stage 1 slow, second tick mid-frame is dropped
        dly = '{3, 50, 3, 3};
        push(51, 4'b0001, 0, 0);
        push(55, 4'b0010, 0, 0);
        push(71, 4'b0000, 0, 1);
        push(106, 4'b0100, 0, 0);
        push(110, 4'b1000, 0, 0);
        push(114, 4'b0000, 1, 0);
        tick_at(50);
        tick_at(70);
        goto(72);
        chk("overrun cnt", int'(o_overrun_cnt), 1);
        goto(120);
        chk("overrun idle after", int'(o_busy), 0);

        // done lands on the watchdog terminal cycle; non-active done bits pulsed meanwhile
        dly = '{64, 1, 1, 1};
        push(131, 4'b0001, 0, 0);
        push(196, 4'b0010, 0, 0);
        push(198, 4'b0100, 0, 0);
        push(200, 4'b1000, 0, 0);
        push(202, 4'b0000, 1, 0);
        tick_at(130);
        goto(135);
        extra_done = 4'b1110;
        goto(140);
        extra_done = 4'b0000;
        chk("stray done cur_phase", int'(o_cur_phase), 0);
        chk("stray done busy", int'(o_busy), 1);
        goto(202);
        chk("done-at-expire timeout", int'(o_timeout_err), 0);

        // timeout in stage 2
        dly = '{1, 1, 0, 1};
        push(221, 4'b0001, 0, 0);
        push(223, 4'b0010, 0, 0);
        push(225, 4'b0100, 0, 0);
        tick_at(220);
        goto(289);
        chk("timeout err@289", int'(o_timeout_err), 0);
        chk("timeout busy@289", int'(o_busy), 1);
        goto(290);
        chk("timeout err@290", int'(o_timeout_err), 1);
        chk("timeout busy@290", int'(o_busy), 0);
        chk("timeout cur_phase", int'(o_cur_phase), 2);
        dly = '{1, 1, 1, 1};
        push(301, 4'b0001, 0, 0);
        push(303, 4'b0010, 0, 0);
        push(305, 4'b0100, 0, 0);
        push(307, 4'b1000, 0, 0);
        push(309, 4'b0000, 1, 0);
        tick_at(300);
        goto(310);
        chk("timeout sticky", int'(o_timeout_err), 1);

        // pause blocks ticks in IDLE; pause raised mid-frame does not stop the frame
        goto(320);
        i_pause = 1'b1;
        tick_at(322);
        tick_at(325);
        tick_at(328);
        goto(330);
        chk("pause busy", int'(o_busy), 0);
        chk("pause ovr_cnt", int'(o_overrun_cnt), 1);
        goto(331);
        i_pause = 1'b0;
        dly = '{3, 3, 3, 3};
        push(336, 4'b0001, 0, 0);
        push(340, 4'b0010, 0, 0);
        push(344, 4'b0100, 0, 0);
        push(348, 4'b1000, 0, 0);
        push(352, 4'b0000, 1, 0);
        tick_at(335);
        goto(338);
        i_pause = 1'b1;
        goto(345);
        chk("pause mid busy", int'(o_busy), 1);
        goto(355);
        i_pause = 1'b0;

        // tick held high over two frames saturates the overrun counter; reset lands in stage 1
        dly = '{60, 60, 60, 60};
        for (int c = 361; c <= 670; c++)
            push(c, (c == 361 || c == 606) ? 4'b0001 : (c == 422 || c == 667) ? 4'b0010 :
                    (c == 483) ? 4'b0100 : (c == 544) ? 4'b1000 : 4'b0000,
                 c == 605, c != 361 && c != 606);
        goto(360);
        i_frame_tick = 1'b1;
        goto(615);
        chk("sat cnt@615", int'(o_overrun_cnt), 254);
        goto(616);
        chk("sat cnt@616", int'(o_overrun_cnt), 255);
        goto(668);
        chk("sat stage", int'(o_cur_phase), 1);
        goto(670);
        i_frame_tick = 1'b0;
        i_rst = 1'b0;
        chk("sat cnt@670", int'(o_overrun_cnt), 255);
        goto(672);
        chk("midreset busy", int'(o_busy), 0);
        chk("midreset cur_phase", int'(o_cur_phase), 0);
        chk("midreset ovr_cnt", int'(o_overrun_cnt), 0);
        chk("midreset timeout", int'(o_timeout_err), 0);
        chk("midreset start", int'(o_phase_start), 0);
        goto(675);
        i_rst = 1'b1;

        // three minimum-length frames (done one cycle after each start)
        dly = '{1, 1, 1, 1};
        for (int f = 0; f < 3; f++) begin
            push(741 + 10 * f, 4'b0001, 0, 0);
            push(743 + 10 * f, 4'b0010, 0, 0);
            push(745 + 10 * f, 4'b0100, 0, 0);
            push(747 + 10 * f, 4'b1000, 0, 0);
            push(749 + 10 * f, 4'b0000, 1, 0);
        end
        tick_at(740);
        goto(748);
        chk("min frame busy@748", int'(o_busy), 1);
        goto(749);
        chk("min frame busy@749", int'(o_busy), 0);
        tick_at(750);
        tick_at(760);
        goto(770);
        chk("final busy", int'(o_busy), 0);
`ifdef FRAME_PHASE_SCHED_FRAME_CNT_EN
        chk("frame_cnt", int'(o_frame_cnt), 3);
`endif
        goto(780);
        chk("events outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
